// File: rtl/window_raster_scanner.sv
// Window raster scanner: walks window centres over a frame and
// streams every clamped kernel tap with its linear pixel address.
module window_raster_scanner #(
  parameter int COORD_W = 8,
  parameter int LIN_W   = 16,
  parameter int IMG_W   = 240,
  parameter int IMG_H   = 180,
  parameter int X_START = 1,
  parameter int Y_START = 1,
  parameter int X_STEP  = 3,
  parameter int Y_STEP  = 3,
  parameter int KERNEL  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               serpentine,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [LIN_W-1:0]   lin_addr,
  output logic [COORD_W-1:0] centre_x,
  output logic [COORD_W-1:0] centre_y,
  output logic               win_first,
  output logic               win_last,
  output logic               busy,
  output logic               frame_done
);

  localparam int R    = (KERNEL - 1) / 2;
  localparam int XMAX = X_START
    + ((IMG_W - 1 - X_START) / X_STEP) * X_STEP;
  localparam int YMAX = Y_START
    + ((IMG_H - 1 - Y_START) / Y_STEP) * Y_STEP;
  localparam int TW   = 3;
  localparam int SW   = COORD_W + 2;

  localparam logic [COORD_W-1:0] XS   = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] YS   = COORD_W'(Y_START);
  localparam logic [COORD_W-1:0] XM   = COORD_W'(XMAX);
  localparam logic [COORD_W-1:0] YM   = COORD_W'(YMAX);
  localparam logic [COORD_W-1:0] XSTP = COORD_W'(X_STEP);
  localparam logic [COORD_W-1:0] YSTP = COORD_W'(Y_STEP);
  localparam logic [COORD_W-1:0] XHI  = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] YHI  = COORD_W'(IMG_H - 1);
  localparam logic [TW-1:0]      TMAX = TW'(KERNEL - 1);
  localparam logic signed [SW-1:0] RS = SW'(R);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] cx_q, cx_d;
  logic [COORD_W-1:0] cy_q, cy_d;
  logic [TW-1:0]      tx_q, tx_d;
  logic [TW-1:0]      ty_q, ty_d;
  logic               serp_q, serp_d;
  logic               odd_q, odd_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [LIN_W-1:0]   lin_q, lin_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               load;

  logic fire;
  logic leftward;
  logic row_end;
  logic last_win;

  function automatic logic [COORD_W-1:0] clampc(
    input logic [COORD_W-1:0] c,
    input logic [TW-1:0]      t,
    input logic [COORD_W-1:0] hi
  );
    logic signed [SW-1:0] v;
    v = $signed({2'b00, c})
      + $signed({{(SW-TW){1'b0}}, t}) - RS;
    if (v < 0) begin
      clampc = '0;
    end else if (v > $signed({2'b00, hi})) begin
      clampc = hi;
    end else begin
      clampc = v[COORD_W-1:0];
    end
  endfunction

  assign fire     = valid_q && out_ready;
  assign leftward = serp_q && odd_q;
  assign row_end  = leftward ? (cx_q == XS)
                             : (cx_q == XM);
  assign last_win = (cy_q == YM) && row_end;

  // Next-state: tap walk, centre advance and frame control
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    serp_d  = serp_q;
    odd_d   = odd_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          cx_d    = XS;
          cy_d    = YS;
          tx_d    = '0;
          ty_d    = '0;
          serp_d  = serpentine;
          odd_d   = 1'b0;
          valid_d = 1'b1;
          load    = 1'b1;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (fire) begin
          load = 1'b1;
          if (tx_q != TMAX) begin
            tx_d = tx_q + 1'b1;
          end else if (ty_q != TMAX) begin
            tx_d = '0;
            ty_d = ty_q + 1'b1;
          end else if (last_win) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            load    = 1'b0;
          end else begin
            tx_d = '0;
            ty_d = '0;
            if (row_end) begin
              cy_d  = cy_q + YSTP;
              odd_d = !odd_q;
              cx_d  = (serp_q && !odd_q) ? XM : XS;
            end else if (leftward) begin
              cx_d = cx_q - XSTP;
            end else begin
              cx_d = cx_q + XSTP;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    x_d     = clampc(cx_d, tx_d, XHI);
    y_d     = clampc(cy_d, ty_d, YHI);
    lin_d   = LIN_W'(int'(y_d) * IMG_W + int'(x_d));
    first_d = (tx_d == '0) && (ty_d == '0);
    last_d  = (tx_d == TMAX) && (ty_d == TMAX);
  end

  // State, scan position and registered tap outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      serp_q  <= 1'b0;
      odd_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      lin_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      serp_q  <= serp_d;
      odd_q   <= odd_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (load) begin
        x_q     <= x_d;
        y_q     <= y_d;
        lin_q   <= lin_d;
        first_q <= first_d;
        last_q  <= last_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign lin_addr   = lin_q;
  assign centre_x   = cx_q;
  assign centre_y   = cy_q;
  assign win_first  = first_q;
  assign win_last   = last_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule
